// File: rtl/sum_tx_buf_if.sv
// Byte-stream input and UART status bundle for sum_tx_buf.
`timescale 1ns/1ps
interface sum_tx_buf_if;
  logic       pi_flag;
  logic [7:0] pi_data;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_cnt;
  logic       ovf;

  modport master (
    output pi_flag, pi_data,
    input  tx, busy, fifo_cnt, ovf
  );

  modport slave (
    input  pi_flag, pi_data,
    output tx, busy, fifo_cnt, ovf
  );
endinterface

// File: rtl/sum_tx_buf.sv
// 16-deep byte FIFO feeding an 8N1 UART transmitter.
// Column-sum results arrive as single-cycle strobes and are serialised
// back-to-back; a byte arriving while the FIFO is full is dropped and
// flagged with a sticky overflow bit.
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); pops the next byte without an idle gap
`timescale 1ns/1ps
module sum_tx_buf #(
  parameter int CLK_FREQ     = 50_000_000,
  parameter int UART_BPS     = 9600,
  parameter int BAUD_CNT_MAX = CLK_FREQ / UART_BPS
) (
  input logic         sys_clk,
  input logic         sys_rst_n,
  sum_tx_buf_if.slave bus
);

  localparam int             BW        = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
  localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_CNT_MAX - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    mem_q [16];
  logic [7:0]    mem_d [16];
  logic [3:0]    wr_ptr_q, wr_ptr_d;
  logic [3:0]    rd_ptr_q, rd_ptr_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;

  logic          full;
  logic          push;
  logic          pop;
  logic          baud_end;

  assign full     = (cnt_q == 5'd16);
  assign push     = bus.pi_flag && !full;
  assign baud_end = (baud_q == BAUD_LAST);

  // FSM next state, baud/bit counters, shift register and pop request
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (cnt_q != 5'd0) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (cnt_q != 5'd0) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line level and busy follow the state being entered so both are registered
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO storage, pointers, occupancy and sticky overflow
  always_comb begin
    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = bus.pi_data;
    end
    wr_ptr_d = wr_ptr_q + {3'b000, push};
    rd_ptr_d = rd_ptr_q + {3'b000, pop};
    cnt_d    = cnt_q + {4'b0000, push} - {4'b0000, pop};
    ovf_d    = ovf_q | (bus.pi_flag && full);
  end

  // All state registers; reset aborts any frame and empties the FIFO
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h00;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.tx       = tx_q;
  assign bus.busy     = busy_q;
  assign bus.fifo_cnt = cnt_q;
  assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_sum_tx_buf.sv
// Bench for sum_tx_buf with a 4-clock bit period: directed strobes push the
// bytes expected on the line into a queue; a negedge UART receiver decodes
// every frame, checks its shape and compares it against the queue head.
`timescale 1ns/1ps
module tb_sum_tx_buf;

  logic clk;
  logic rst_n;

  sum_tx_buf_if bus ();

  sum_tx_buf #(
    .CLK_FREQ (40),
    .UART_BPS (10)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_err    = 0;
  logic [7:0] exp_q [$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- UART receiver / scoreboard ----------------
  bit         mon_active = 1'b0;
  int         mon_pos    = 0;
  bit         mon_ok     = 1'b1;
  logic       mon_cur    = 1'b1;
  logic [7:0] mon_rx     = 8'h00;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 1'b0;
    end else begin
      if (!mon_active && bus.tx == 1'b0) begin
        mon_active = 1'b1;
        mon_pos    = 0;
        mon_ok     = 1'b1;
        mon_rx     = 8'h00;
      end
      if (mon_active) begin
        if (bus.busy !== 1'b1) mon_ok = 1'b0;
        if (mon_pos < 4) begin
          if (bus.tx !== 1'b0) mon_ok = 1'b0;
        end else if (mon_pos < 36) begin
          if (((mon_pos - 4) % 4) == 0) begin
            mon_cur = bus.tx;
            mon_rx[3'((mon_pos - 4) / 4)] = bus.tx;
          end else if (bus.tx !== mon_cur) begin
            mon_ok = 1'b0;
          end
        end else begin
          if (bus.tx !== 1'b1) mon_ok = 1'b0;
        end
        if (mon_pos == 39) begin
          check("frame_shape", int'(mon_ok), 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_frame: got %02h expected none at %0t", mon_rx, $time);
          end else begin
            mon_exp = exp_q.pop_front();
            check("frame_byte", int'(mon_rx), int'(mon_exp));
          end
          mon_active = 1'b0;
        end
        mon_pos++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic strobe(input logic [7:0] b, input bit keep);
    bus.pi_flag = 1'b1;
    bus.pi_data = b;
    if (keep) exp_q.push_back(b);
    @(posedge clk);
    #1;
    bus.pi_flag = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int  n    = 0;
    bit  done = 1'b0;
    while (!done && n < max_cyc) begin
      if (!bus.busy && bus.fifo_cnt == 5'd0 && !mon_active) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    if (!done) begin
      n_checks++;
      n_err++;
      $display("FAIL wait_idle: got busy=%0d cnt=%0d expected idle within %0d cycles",
               bus.busy, bus.fifo_cnt, max_cyc);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int peak;
    int c1, c2, c3;

    bus.pi_flag = 1'b0;
    bus.pi_data = 8'h00;
    rst_n       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx",   int'(bus.tx), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_cnt",  int'(bus.fifo_cnt), 0);
    check("rst_ovf",  int'(bus.ovf), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // single byte: latency, frame length, occupancy 1 -> 0
    strobe(8'hA5, 1'b1);
    check("a5_cnt_e1",  int'(bus.fifo_cnt), 1);
    check("a5_tx_e1",   int'(bus.tx), 1);
    check("a5_busy_e1", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    check("a5_tx_e2",   int'(bus.tx), 0);
    check("a5_busy_e2", int'(bus.busy), 1);
    check("a5_cnt_e2",  int'(bus.fifo_cnt), 0);
    n = 1;
    while (bus.busy && n < 200) begin
      @(posedge clk);
      #1;
      if (bus.busy) n++;
    end
    check("a5_busy_len", n, 40);
    wait_idle(100);

    // three consecutive strobes: contiguous frames, peak occupancy 2
    strobe(8'h01, 1'b1);
    c1 = bus.fifo_cnt;
    strobe(8'h02, 1'b1);
    c2 = bus.fifo_cnt;
    strobe(8'h03, 1'b1);
    c3 = bus.fifo_cnt;
    check("b3_cnt1", c1, 1);
    check("b3_cnt2", c2, 1);
    check("b3_cnt3", c3, 2);
    peak = c3;
    n    = 2;
    while (bus.busy && n < 400) begin
      @(posedge clk);
      #1;
      if (bus.fifo_cnt > peak) peak = bus.fifo_cnt;
      if (bus.busy) n++;
    end
    check("b3_peak", peak, 2);
    check("b3_busy_len", n, 120);
    wait_idle(100);

    // 18 strobes from empty: 17 kept, last dropped, ovf sticky
    for (int i = 0; i < 17; i++) strobe(8'h80 + 8'(i), 1'b1);
    check("o18_cnt_full", int'(bus.fifo_cnt), 16);
    check("o18_ovf_pre",  int'(bus.ovf), 0);
    strobe(8'hFF, 1'b0);
    check("o18_cnt_drop", int'(bus.fifo_cnt), 16);
    check("o18_ovf",      int'(bus.ovf), 1);
    wait_idle(1000);
    check("o18_ovf_sticky", int'(bus.ovf), 1);

    // strobe on the edge of the STOP-end pop while full
    do_reset();
    check("r_ovf_clear", int'(bus.ovf), 0);
    for (int i = 0; i < 17; i++) strobe(8'hC0 + 8'(i), 1'b1);
    check("p_cnt_full", int'(bus.fifo_cnt), 16);
    repeat (24) @(posedge clk);
    #1;
    check("p_cnt_pre", int'(bus.fifo_cnt), 16);
    check("p_ovf_pre", int'(bus.ovf), 0);
    strobe(8'hEE, 1'b0);
    check("p_ovf",  int'(bus.ovf), 1);
    check("p_cnt",  int'(bus.fifo_cnt), 15);
    wait_idle(1000);

    // reset during data bit 3 aborts the frame and flushes the FIFO
    do_reset();
    strobe(8'h5A, 1'b1);
    strobe(8'h77, 1'b1);
    repeat (17) @(posedge clk);
    #1;
    check("m_busy_pre", int'(bus.busy), 1);
    check("m_cnt_pre",  int'(bus.fifo_cnt), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("m_tx_rst",   int'(bus.tx), 1);
    check("m_busy_rst", int'(bus.busy), 0);
    check("m_cnt_rst",  int'(bus.fifo_cnt), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    strobe(8'h3C, 1'b1);
    @(posedge clk);
    #1;
    check("m_3c_tx", int'(bus.tx), 0);
    wait_idle(200);

    // pointer wrap: 4 bursts of 10 with drain between
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 10; i++) strobe(8'(b * 10 + i) ^ 8'h5C, 1'b1);
      wait_idle(600);
    end
    check("w_ovf", int'(bus.ovf), 0);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
